// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between fetch and imem.
// The master drives req/addr; the slave answers with ack and same-cycle rdata.
interface fetch_stage_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register, a one-entry skid
// buffer for stalls, and a discard state for redirects under an open request.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    fetch_stage_if.master        imem_bus,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    output logic                 if_id_valid_o,
    output logic [31:0]          if_id_instr_o,
    output logic [31:0]          if_id_pc_o,
    output logic [31:0]          if_id_pc_plus4_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_pc4;

    logic        w_ack;
    logic [31:0] w_rpc;
    logic        w_fetch_del;
    logic        w_hold_del;
    logic        w_del;
    logic [31:0] w_del_instr;
    logic [31:0] w_del_pc;

    assign w_ack = imem_bus.imem_ack_i;
    assign w_rpc = redirect_pc_i & ~32'd3;

    // The pending request keeps r_pc on the port until its ack arrives.
    assign imem_bus.imem_req_o  = (r_state == S_FETCH) ||
                                  (r_state == S_DISCARD);
    assign imem_bus.imem_addr_o = r_pc;

    assign w_fetch_del = (r_state == S_FETCH) && w_ack &&
                         !redirect_i && !stall_i;
    assign w_hold_del  = (r_state == S_HOLD) &&
                         !redirect_i && !stall_i;
    assign w_del       = w_fetch_del || w_hold_del;
    assign w_del_instr = w_hold_del ? r_skid_instr
                                    : imem_bus.imem_rdata_i;
    assign w_del_pc    = w_hold_del ? r_skid_pc : r_pc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_pend_pc    <= 32'd0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (redirect_i) begin
                        if (w_ack) begin
                            r_pc <= w_rpc;
                        end else begin
                            r_pend_pc <= w_rpc;
                            r_state   <= S_DISCARD;
                        end
                    end else if (w_ack) begin
                        r_pc <= r_pc + 32'd4;
                        if (stall_i) begin
                            r_skid_instr <= imem_bus.imem_rdata_i;
                            r_skid_pc    <= r_pc;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect_i) begin
                        r_pc    <= w_rpc;
                        r_state <= S_FETCH;
                    end else if (!stall_i) begin
                        r_state <= S_FETCH;
                    end
                end
                S_DISCARD: begin
                    if (w_ack) begin
                        r_pc    <= redirect_i ? w_rpc : r_pend_pc;
                        r_state <= S_FETCH;
                    end else if (redirect_i) begin
                        r_pend_pc <= w_rpc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid  <= 1'b0;
            r_instr  <= NOP_INSTR;
            r_id_pc  <= 32'd0;
            r_id_pc4 <= 32'd0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!stall_i) begin
            if (w_del) begin
                r_valid  <= 1'b1;
                r_instr  <= w_del_instr;
                r_id_pc  <= w_del_pc;
                r_id_pc4 <= w_del_pc + 32'd4;
            end else begin
                r_valid <= 1'b0;
                r_instr <= NOP_INSTR;
            end
        end
    end

    assign if_id_valid_o    = r_valid;
    assign if_id_instr_o    = r_instr;
    assign if_id_pc_o       = r_id_pc;
    assign if_id_pc_plus4_o = r_id_pc4;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register. It feeds the decode stage, whose register-file reads and forwarding logic consume `if_id_*`. It owns the PC and drives a req/ack instruction-memory port. It also handles decode-side stall, flush and branch/jump redirects, including a redirect that arrives while a fetch is still outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction injected on bubbles/flush (`addi x0,x0,0`).

Ports:
- `clk_i` in 1: clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `imem_req_o` out 1: fetch request.
- `imem_addr_o` out 32: fetch address, word-aligned.
- `imem_ack_i` in 1: request accepted; `imem_rdata_i` valid in the same cycle.
- `imem_rdata_i` in 32: fetched instruction.
- `stall_i` in 1: hold IF/ID contents (load-use hazard from decode).
- `flush_i` in 1: squash IF/ID contents.
- `redirect_i` in 1: PC redirect (taken branch/jump).
- `redirect_pc_i` in 32: redirect target; bits [1:0] ignored and forced to 0.
- `if_id_valid_o` out 1: IF/ID holds a real instruction.
- `if_id_instr_o` out 32: instruction to decode.
- `if_id_pc_o` out 32: PC of that instruction.
- `if_id_pc_plus4_o` out 32: `if_id_pc_o + 4`, mod 2^32.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, pc = RESET_PC.
  - `if_id_valid_o` = 0, `if_id_instr_o` = NOP_INSTR, `if_id_pc_o` = 0, `if_id_pc_plus4_o` = 0.
  - `imem_req_o` = 0, skid buffer cleared.
- Port rules:
  - `imem_req_o` = 1 exactly in FETCH and DISCARD.
  - `imem_addr_o` = pc in FETCH and the pending-request address in DISCARD.
  - Address is stable while req=1 and ack=0.
- FSM states: IDLE, FETCH, HOLD, DISCARD.
  - IDLE -> FETCH unconditionally, one cycle after reset release.
  - FETCH, ack=0, no redirect: stay, pc unchanged.
  - FETCH, ack=1, no redirect, stall=0: deliver `imem_rdata_i`/pc to IF/ID; pc += 4; stay in FETCH. Back-to-back acks give one instruction per cycle.
  - FETCH, ack=1, no redirect, stall=1: capture rdata/pc into the skid buffer; pc += 4; -> HOLD (req drops).
  - FETCH, redirect=1, ack=1: discard rdata; pc = redirect_pc; stay in FETCH.
  - FETCH, redirect=1, ack=0: latch pending_pc = redirect_pc; -> DISCARD. The old address stays on the port.
  - HOLD, redirect=1: drop the skid buffer; pc = redirect_pc; -> FETCH.
  - HOLD, stall=0, no redirect: load the skid buffer into IF/ID; -> FETCH.
  - HOLD, stall=1: stay.
  - DISCARD, redirect=1: pending_pc updated; the newest redirect wins.
  - DISCARD, ack=1: drop rdata; pc = pending_pc (or redirect_pc if redirect is asserted the same cycle); -> FETCH.
- IF/ID register update, in priority order:
  - flush_i = 1: valid = 0, instr = NOP_INSTR. pc fields don't care; hold them.
  - else stall_i = 1: hold all fields.
  - else an instruction is delivered (as above): valid = 1, load instr/pc/pc+4.
  - else: bubble, valid = 0, instr = NOP_INSTR.
- Flush and redirect are independent inputs; decode normally asserts both together.
- Flush with stall: flush wins; a buffered HOLD instruction is kept unless redirect is also asserted.
- pc arithmetic: 32-bit wrap; 0xFFFF_FFFC + 4 = 0x0000_0000, with no flag.
- Latency: ack in cycle N gives IF/ID valid from cycle N+1.
- Reset mid-request: state returns to IDLE immediately and `imem_req_o` drops asynchronously. A late ack after reset in IDLE is ignored.

Test Plan:
- Reset release, ack tied high, rdata = 0xAAA0_0000 + addr:
  - cycle 1 req with addr 0x0;
  - IF/ID sequence pc 0x0/0x4/0x8…, instr 0xAAA0_0000/0xAAA0_0004…, valid = 1 each cycle after the first ack.
- Ack delayed 3 cycles per fetch:
  - addr stable through each wait;
  - IF/ID valid = 0 (NOP_INSTR) during waits, valid = 1 for one cycle per instruction.
- stall_i = 1 for 4 cycles while ack arrives for pc 0x10:
  - IF/ID holds its prior instruction; req = 0 during HOLD;
  - after release IF/ID = pc 0x10, then the next request is at 0x14.
- Redirect to 0x200 while request 0x20 is pending, ack 2 cycles later:
  - addr stays 0x20 until ack; that data is never valid in IF/ID;
  - the next request is at 0x200.
- Redirect to 0x300 and flush together on an ack cycle:
  - IF/ID valid = 0, instr = 0x0000_0013;
  - next addr 0x300.
- RESET_PC = 0xFFFF_FFF8, ack high:
  - fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000;
  - `if_id_pc_plus4_o` for 0xFFFF_FFFC = 0x0000_0000.
